// File: rtl/sh_dmac_nch.sv
// sh_dmac_nch: N-channel dual-address DMA controller for SH-family cores.
// Channels are programmed over the peripheral bus; the data bus is mastered through REQ/WAIT.
module sh_dmac_nch #(
    parameter int CH_NUM = 4,
    parameter int TCR_W  = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ce,
    input  logic [7:0]        i_reg_a,
    input  logic [31:0]       i_reg_di,
    input  logic              i_reg_we,
    input  logic              i_reg_req,
    output logic [31:0]       o_reg_do,
    input  logic [CH_NUM-1:0] i_dreq,
    output logic [CH_NUM-1:0] o_dack,
    output logic [31:0]       o_dbus_a,
    input  logic [31:0]       i_dbus_di,
    output logic [31:0]       o_dbus_do,
    output logic [3:0]        o_dbus_ba,
    output logic              o_dbus_we,
    output logic              o_dbus_req,
    input  logic              i_dbus_wait,
    output logic [CH_NUM-1:0] o_irq
);
    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    // Field order matches the CHCR bit layout [10:0].
    typedef struct packed {
        logic       rl;
        logic [1:0] dm;
        logic [1:0] sm;
        logic [1:0] ts;
        logic       ar;
        logic       ie;
        logic       te;
        logic       de;
    } chcr_t;

    function automatic logic [31:0] f_step(input logic [1:0] mode, input logic [1:0] ts);
        logic [31:0] size;
        size = ts[1] ? 32'd4 : (ts[0] ? 32'd2 : 32'd1);
        case (mode)
            2'b01:   f_step = size;
            2'b10:   f_step = 32'd0 - size;
            default: f_step = 32'd0;
        endcase
    endfunction

    function automatic logic f_misaligned(input logic [1:0] a, input logic [1:0] ts);
        if (ts[1])      f_misaligned = |a;
        else if (ts[0]) f_misaligned = a[0];
        else            f_misaligned = 1'b0;
    endfunction

    // Big-endian lanes: byte offset 0 lives in [31:24].
    function automatic logic [3:0] f_ba(input logic [1:0] a, input logic [1:0] ts);
        if (ts[1])      f_ba = 4'hF;
        else if (ts[0]) f_ba = a[1] ? 4'b0011 : 4'b1100;
        else            f_ba = 4'b1000 >> a;
    endfunction

    function automatic logic [31:0] f_lane(input logic [31:0] d, input logic [1:0] a,
                                           input logic [1:0] ts);
        if (ts[1])      f_lane = d;
        else if (ts[0]) f_lane = a[1] ? {2{d[15:0]}} : {2{d[31:16]}};
        else begin
            case (a)
                2'd0:    f_lane = {4{d[31:24]}};
                2'd1:    f_lane = {4{d[23:16]}};
                2'd2:    f_lane = {4{d[15:8]}};
                default: f_lane = {4{d[7:0]}};
            endcase
        end
    endfunction

    logic [31:0]      r_sar    [CH_NUM];
    logic [31:0]      r_dar    [CH_NUM];
    logic [TCR_W-1:0] r_tcr    [CH_NUM];
    logic [31:0]      r_sar_rl [CH_NUM];
    logic [31:0]      r_dar_rl [CH_NUM];
    logic [TCR_W-1:0] r_tcr_rl [CH_NUM];
    chcr_t            r_chcr   [CH_NUM];
    logic             r_dme, r_pr, r_ae;
    state_t           r_state, w_next_state;
    logic [CW-1:0]    r_ch, r_last, w_grant;
    logic [31:0]      r_data, r_reg_do, w_rd_data;
    logic [CH_NUM-1:0] w_elig;
    logic             w_any, w_mis;
    logic [TCR_W-1:0] w_tcr_dec;
    logic             w_unused;

    // Low address bits are ignored: every register is longword aligned.
    assign w_unused  = &{1'b0, i_reg_a[1:0]};
    assign w_any     = |w_elig;
    assign w_tcr_dec = r_tcr[r_ch] - TCR_W'(1);
    assign o_reg_do  = r_reg_do;

    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            w_elig[c] = r_dme & r_chcr[c].de & ~r_ae & (~r_chcr[c].te | r_chcr[c].rl)
                      & (r_chcr[c].ar | i_dreq[c]);
            o_irq[c]  = r_chcr[c].te & r_chcr[c].ie;
        end
    end

    // Fixed priority scans from 0; round-robin scans from the slot after the last grant.
    always_comb begin : p_arb
        int   idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        w_grant = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            idx = r_pr ? (int'(r_last) + 1 + k) % CH_NUM : k;
            if (w_elig[idx] && !found) begin
                w_grant = CW'(idx);
                found   = 1'b1;
            end
        end
        w_mis = f_misaligned(r_sar[w_grant][1:0], r_chcr[w_grant].ts)
              | f_misaligned(r_dar[w_grant][1:0], r_chcr[w_grant].ts);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any && !w_mis) w_next_state = S_RD;
            S_RD:    if (!i_dbus_wait)    w_next_state = S_WR;
            S_WR:    if (!i_dbus_wait)    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_dbus_a   = '0;
        o_dbus_do  = '0;
        o_dbus_ba  = '0;
        o_dbus_we  = 1'b0;
        o_dbus_req = 1'b0;
        o_dack     = '0;
        case (r_state)
            S_RD: begin
                o_dbus_req   = 1'b1;
                o_dbus_a     = r_sar[r_ch];
                o_dbus_ba    = f_ba(r_sar[r_ch][1:0], r_chcr[r_ch].ts);
                o_dack[r_ch] = 1'b1;
            end
            S_WR: begin
                o_dbus_req   = 1'b1;
                o_dbus_we    = 1'b1;
                o_dbus_a     = r_dar[r_ch];
                o_dbus_do    = r_data;
                o_dbus_ba    = f_ba(r_dar[r_ch][1:0], r_chcr[r_ch].ts);
                o_dack[r_ch] = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        if (i_reg_a == 8'hFC) w_rd_data = {29'd0, r_ae, r_pr, r_dme};
        for (int c = 0; c < CH_NUM; c++) begin
            if (i_reg_a[7:4] == 4'(c)) begin
                case (i_reg_a[3:2])
                    2'd0:    w_rd_data = r_sar[c];
                    2'd1:    w_rd_data = r_dar[c];
                    2'd2:    w_rd_data = 32'(r_tcr[c]);
                    default: w_rd_data = {21'd0, r_chcr[c]};
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_ch     <= '0;
            r_last   <= CW'(CH_NUM - 1);
            r_data   <= '0;
            r_reg_do <= '0;
            r_dme    <= 1'b0;
            r_pr     <= 1'b0;
            r_ae     <= 1'b0;
            // NOTE: the channel arrays are flops, so they are cleared like any register;
            // a stale address must never be able to start a transfer after reset.
            for (int c = 0; c < CH_NUM; c++) begin
                r_sar[c]    <= '0;
                r_dar[c]    <= '0;
                r_tcr[c]    <= '0;
                r_sar_rl[c] <= '0;
                r_dar_rl[c] <= '0;
                r_tcr_rl[c] <= '0;
                r_chcr[c]   <= '0;
            end
        end else if (i_ce) begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_any) begin
                if (w_mis) begin
                    r_ae <= 1'b1;
                end else begin
                    r_ch   <= w_grant;
                    r_last <= w_grant;
                end
            end
            if (r_state == S_RD && !i_dbus_wait)
                r_data <= f_lane(i_dbus_di, r_sar[r_ch][1:0], r_chcr[r_ch].ts);
            if (r_state == S_WR && !i_dbus_wait) begin
                r_sar[r_ch] <= r_sar[r_ch] + f_step(r_chcr[r_ch].sm, r_chcr[r_ch].ts);
                r_dar[r_ch] <= r_dar[r_ch] + f_step(r_chcr[r_ch].dm, r_chcr[r_ch].ts);
                r_tcr[r_ch] <= w_tcr_dec;
                if (w_tcr_dec == '0) begin
                    r_chcr[r_ch].te <= 1'b1;
                    if (r_chcr[r_ch].rl) begin
                        r_sar[r_ch] <= r_sar_rl[r_ch];
                        r_dar[r_ch] <= r_dar_rl[r_ch];
                        r_tcr[r_ch] <= r_tcr_rl[r_ch];
                    end
                end
            end
            // NOTE: register writes sit after the hardware updates; the later non-blocking
            // assignment wins, which gives software priority on the same field and cycle.
            if (i_reg_req) begin
                if (!i_reg_we) begin
                    r_reg_do <= w_rd_data;
                end else if (i_reg_a == 8'hFC) begin
                    r_dme <= i_reg_di[0];
                    r_pr  <= i_reg_di[1];
                    if (!i_reg_di[2]) r_ae <= 1'b0;
                end else begin
                    for (int c = 0; c < CH_NUM; c++) begin
                        if (i_reg_a[7:4] == 4'(c)) begin
                            case (i_reg_a[3:2])
                                2'd0: begin
                                    r_sar[c]    <= i_reg_di;
                                    r_sar_rl[c] <= i_reg_di;
                                end
                                2'd1: begin
                                    r_dar[c]    <= i_reg_di;
                                    r_dar_rl[c] <= i_reg_di;
                                end
                                2'd2: begin
                                    r_tcr[c]    <= i_reg_di[TCR_W-1:0];
                                    r_tcr_rl[c] <= i_reg_di[TCR_W-1:0];
                                end
                                default: begin
                                    r_chcr[c].de <= i_reg_di[0];
                                    r_chcr[c].ie <= i_reg_di[2];
                                    r_chcr[c].ar <= i_reg_di[3];
                                    r_chcr[c].ts <= i_reg_di[5:4];
                                    r_chcr[c].sm <= i_reg_di[7:6];
                                    r_chcr[c].dm <= i_reg_di[9:8];
                                    r_chcr[c].rl <= i_reg_di[10];
                                    if (!i_reg_di[1]) r_chcr[c].te <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
            end
        end
    end
endmodule

// File: doc/sh_dmac_nch.md
# sh_dmac_nch

Parametrised N-channel dual-address DMA controller for the SH-family CPU cores. It is the successor to the two-channel SH7604 on-chip DMAC. It is register-programmed over the internal peripheral bus and masters the shared data bus through a REQ/WAIT handshake. Compared with the two-channel part it adds:
- configurable channel count and transfer-counter width;
- arbitration among any number of channels;
- per-channel auto-reload (ring) mode;
- misalignment detection.

## Interface
Parameters:
- CH_NUM, 4: number of channels, 1..8.
- TCR_W, 24: transfer-counter width, 8..24.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- CE  in  1  clock enable; all state advances only on CLK edges with CE=1.
- REG_A  in  8  register byte address, longword aligned.
- REG_DI  in  32  register write data.
- REG_WE  in  1  1 = write, 0 = read.
- REG_REQ  in  1  register access strobe.
- REG_DO  out  32  registered read data.
- DREQ  in  CH_NUM  per-channel external request, level, active high.
- DACK  out  CH_NUM  per-channel acknowledge.
- DBUS_A  out  32  bus address.
- DBUS_DI  in  32  bus read data.
- DBUS_DO  out  32  bus write data.
- DBUS_BA  out  4  byte enables, bit 3 = byte lane [31:24].
- DBUS_WE  out  1  bus write.
- DBUS_REQ  out  1  bus request.
- DBUS_WAIT  in  1  bus stall.
- IRQ  out  CH_NUM  per-channel transfer-end interrupt.

## Operation
Register map:
- Channel c base is c*0x10. Offsets: SAR 0x0, DAR 0x4, TCR 0x8, CHCR 0xC.
- DMAOR is at 0xFC.
- Unmapped addresses read 0; writes to them are ignored.

CHCR bits:
- [0] DE: channel enable.
- [1] TE: transfer end. Set by hardware; software can only clear it, by writing 0.
- [2] IE: interrupt enable.
- [3] AR: auto-request.
- [5:4] TS: transfer size. 00 = byte, 01 = word, 1x = long.
- [7:6] SM: source mode. 01 = increment, 10 = decrement, other = fixed.
- [9:8] DM: destination mode, same encoding as SM.
- [10] RL: auto-reload.
- Other bits read 0.

DMAOR bits:
- [0] DME: master enable.
- [1] PR: 0 = fixed priority (lowest index wins), 1 = round-robin.
- [2] AE: address error. Set by hardware; software clears it by writing 0.

Register write behaviour:
- Writes to SAR, DAR or TCR load both the working register and a hidden reload copy.

Channel eligibility:
- A channel is eligible when DME & DE & ~AE & (~TE | RL) & (AR | DREQ[c]).

State machine:
- IDLE: if any channel is eligible, the arbiter picks channel g and the FSM goes to RD.
  - Fixed priority: lowest eligible index.
  - Round-robin: first eligible index after the last grant, wrapping modulo CH_NUM.
  - Misalignment check: if SAR[g] or DAR[g] is misaligned for TS (word: bit 0 set; long: bits 1:0 nonzero), set AE and stay in IDLE. No bus cycle is issued.
- RD: drive DBUS_A=SAR[g], WE=0, REQ=1, BA from address and size.
  - On the CE cycle with WAIT=0: latch the lane-extracted data, replicated across the word, then go to WR.
- WR: drive DBUS_A=DAR[g], WE=1, REQ=1, DO = latched data.
  - On the CE cycle with WAIT=0, update the channel and go to IDLE:
    - SAR and DAR step by ±1, ±2 or ±4 per their modes.
    - TCR decrements, modulo 2^TCR_W.
    - If the new TCR is 0: set TE. If RL=1, also reload SAR, DAR and TCR from their reload copies; the channel stays eligible.
- TCR=0 at start means 2^TCR_W transfers.

Outputs:
- DACK[g] = 1 whenever DBUS_REQ=1 for channel g; otherwise 0.
- IRQ[c] = TE & IE.
- REG_DO is registered and updates one CE cycle after a read strobe.

Simultaneous events:
- A register write and a hardware update to the same field in the same cycle: the register write wins. For TE, a write of 0 beats a hardware set.
- Clearing DE or DME mid-transfer does not abort the current unit. It takes effect at the next IDLE.

Reset:
- All registers and the FSM clear (state IDLE).
- All outputs are 0.
- The round-robin pointer is reset so channel 0 is first.

## Timing
- Eligibility seen in IDLE at cycle n: DBUS_REQ is high at n+1.
- Zero-wait unit: 3 CE cycles (IDLE, RD, WR).
- Each WAIT=1 cycle adds one cycle, with address and control held stable.
- CE=0 freezes all state and outputs.
- DREQ is re-sampled in IDLE after each unit. A device must drop DREQ before the WR completes to avoid an extra unit.
- TE, IRQ and the reload take effect on the edge that completes the final WR.

## Test plan
- Auto-request, ch0, TS=long, SM=DM=01, SAR=0x1000, DAR=0x2000, TCR=3, zero wait -> 3 read/write pairs at 0x1000/0x2000, 0x1004/0x2004, 0x1008/0x2008. TE=1 after 9 cycles. IRQ high if IE=1.
- Byte read from SAR=0x1003, DBUS_DI=0xAABBCCDD -> DBUS_DO=0xDDDDDDDD, write BA=0001 for DAR=0x..3.
- PR=1, channels 0, 2 and 3 all auto-request with TCR=2 -> grant order 0,2,3,0,2,3. With PR=0 -> order 0,0,2,2,3,3.
- RL=1, TCR=2, SAR=0x100 increment -> after 2 units TE=1 and SAR back to 0x100. Transfers continue; clearing DE stops the channel at the next IDLE.
- Word transfer with SAR=0x101 -> AE=1, no DBUS_REQ, all channels blocked until AE is written 0.
- DBUS_WAIT held 4 cycles in RD, and RST asserted during the WR -> address stable while stalled. After reset all outputs are 0 and the FSM is in IDLE.
